// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
// Holds the access-size encodings, the controller state enum, the
// requester-select encoding, the default IO region base and small helpers
// that turn a size code into a byte count.
package mem_ctrl_pkg;

  // Access size codes as presented on mem_size. Code 3 is treated as a word.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Start of the memory-mapped IO region (used by the IO write stall).
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Which requester owns the access in flight.
  typedef enum logic {
    SEL_MEM = 1'b0,
    SEL_IF  = 1'b1
  } sel_e;

  // Fold the reserved size code onto a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_W : size;
  endfunction

  // Number of byte beats needed for a given size code.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_extend.sv
// Load-result extension for the memory controller.
// Purely combinational: takes the assembled little-endian value and
// produces the architectural load result.
// Ports:
//   raw   - assembled bytes (lane 0 in bits 7:0)
//   size  - normalised size code (SIZE_B / SIZE_H / SIZE_W)
//   uns   - 1 = zero-extend byte/half loads, 0 = sign-extend
//   ext   - extended result; word loads pass through untouched
module mem_ctrl_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SIZE_B:  ext = {{24{raw[7] & ~uns}}, raw[7:0]};
      SIZE_H:  ext = {{16{raw[15] & ~uns}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller serving the IF and MEM pipeline stages.
// Each word/half/byte request is broken into single-byte accesses on an
// 8-bit synchronous RAM/IO bus; loads are reassembled little-endian and
// extended, and completion is signalled with a one-cycle done pulse.
//
// Optional feature (macro MEM_CTRL_IO_STALL_EN): stores to addresses at or
// above IO_BASE pause while io_buffer_full is high. Without the macro,
// io_buffer_full and IO_BASE have no effect.
//
// Handshake: a requester raises *_req with stable fields and holds it until
// its *_done pulse. Fields are captured on the accept edge (IDLE with a
// request present, MEM winning over IF); requests seen during DONE are
// ignored, so the next access starts no earlier than one cycle after done.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   if_req/if_addr           - instruction fetch request (always 4 bytes)
//   if_done/if_data          - fetch completion pulse and word
//   mem_req/mem_we/mem_addr/mem_size/mem_unsigned/mem_wdata - load/store
//   mem_done/mem_rdata       - load/store completion pulse and load result
//   ram_a/ram_wr/ram_dout    - byte bus address, write strobe, write byte
//   ram_din                  - read byte, valid one cycle after ram_a
//   io_buffer_full           - IO write buffer back-pressure
//   dbg_state                - current controller state
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 17,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  input  logic              io_buffer_full,
  output state_e            dbg_state
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  sel_e        sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [2:0]  n_q;
  logic [31:0] raw_q;

  logic              accept;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        wr_byte;
  logic [1:0]        lane;
  logic [31:0]       raw_full;
  logic [31:0]       ext;
  logic              stall;

  assign dbg_state = state_q;
  assign accept    = (state_q == IDLE) && (mem_req || if_req);

  // Byte address wraps naturally at 2^ADDR_W.
  assign bus_addr = addr_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
  assign wr_byte  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

  // ram_din in READ cycle k carries the byte addressed in cycle k-1.
  assign lane = cnt_q[1:0] - 2'd1;

  always_comb begin
    raw_full = raw_q;
    raw_full[{lane, 3'b000} +: 8] = ram_din;
  end

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall = (state_q == WRITE) && io_buffer_full &&
                 ((addr_q + 32'(cnt_q)) >= IO_BASE);
`else
  logic io_unused;
  assign stall     = 1'b0;
  assign io_unused = ^{io_buffer_full, IO_BASE, addr_q[31:ADDR_W]};
`endif

  mem_ctrl_extend u_extend (
    .raw  (raw_full),
    .size (size_q),
    .uns  (uns_q),
    .ext  (ext)
  );

  // Next state and bus outputs. The bus is driven purely from the state
  // register, so a reset drops ram_wr in the very next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = 8'd0;
    if_done  = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (mem_req) begin
          state_d = mem_we ? WRITE : READ;
        end else if (if_req) begin
          state_d = READ;
        end
      end
      READ: begin
        // n address cycles plus one cycle to collect the final byte.
        ram_a = bus_addr;
        if (cnt_q == n_q) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        ram_a = bus_addr;
        if (!stall) begin
          ram_wr   = 1'b1;
          ram_dout = wr_byte;
          if (cnt_q == n_q - 3'd1) begin
            state_d = DONE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        if_done  = (sel_q == SEL_IF);
        mem_done = (sel_q == SEL_MEM);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      sel_q     <= SEL_MEM;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      size_q    <= SIZE_W;
      uns_q     <= 1'b0;
      n_q       <= 3'd4;
      raw_q     <= 32'd0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        raw_q <= 32'd0;
        if (mem_req) begin
          sel_q   <= SEL_MEM;
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          size_q  <= norm_size(mem_size);
          uns_q   <= mem_unsigned;
          n_q     <= byte_count(mem_size);
        end else begin
          sel_q   <= SEL_IF;
          addr_q  <= if_addr;
          wdata_q <= 32'd0;
          size_q  <= SIZE_W;
          uns_q   <= 1'b0;
          n_q     <= 3'd4;
        end
      end
      if (state_q == READ && cnt_q != 3'd0) begin
        raw_q <= raw_full;
      end
      // Result registers update on the edge into DONE and hold afterwards.
      if (state_q == READ && cnt_q == n_q) begin
        if (sel_q == SEL_IF) begin
          if_data <= raw_full;
        end else begin
          mem_rdata <= ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-array RAM model on the bus, a
// transaction-level reference memory, directed scenarios and a randomized
// mix of loads, stores and fetches.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 17;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = 32'd0;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [31:0]       mem_addr = 32'd0;
  logic [1:0]        mem_size = 2'd0;
  logic              mem_unsigned = 1'b0;
  logic [31:0]       mem_wdata = 32'd0;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din = 8'd0;
  logic              io_buffer_full = 1'b0;
  state_e            dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus RAM model and write monitor ----------------
  logic [7:0]  ram [0:MEM_SZ-1];
  logic [7:0]  ref_mem [0:MEM_SZ-1];
  logic [24:0] wr_log[$];
  logic [24:0] exp_q[$];
  logic [ADDR_W-1:0] a_trace[$];

  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) begin
      ram[ram_a] <= ram_dout;
      wr_log.push_back({ram_a, ram_dout});
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input bit is_if, input logic [1:0] size);
    if (is_if) return 4;
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input bit uns);
    logic [31:0] v = 32'd0;
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = ADDR_W'(addr + 32'(k));
      v = v | (32'(ref_mem[a]) << (8 * k));
    end
    if (n == 1 && !uns && v[7]) v = v | 32'hFFFF_FF00;
    if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input int n, input logic [31:0] wdata);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = ADDR_W'(addr + 32'(k));
      ref_mem[a] = 8'(wdata >> (8 * k));
      exp_q.push_back({a, 8'(wdata >> (8 * k))});
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input bit is_if, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                        output logic [31:0] got, output int lat, output bit stray);
    bit found = 1'b0;
    @(negedge clk);
    wr_log.delete();
    a_trace.delete();
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_size = size;
      mem_unsigned = uns; mem_wdata = wdata;
    end
    lat = 0; got = 32'd0; stray = 1'b0;
    while (!found && lat < 40) begin
      @(negedge clk);
      lat++;
      a_trace.push_back(ram_a);
      if (is_if ? mem_done : if_done) stray = 1'b1;
      if (is_if ? if_done : mem_done) begin
        found = 1'b1;
        got = is_if ? if_data : mem_rdata;
      end
      // Fields after the accept edge must not matter.
      if (lat == 1) begin
        if (is_if) if_addr = $urandom;
        else begin
          mem_addr = $urandom; mem_wdata = $urandom; mem_size = 2'($urandom);
          mem_unsigned = 1'($urandom); mem_we = 1'($urandom);
        end
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    if (!found) lat = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    n_cmp++; if (ram_a !== '0) begin n_bad++; $display("FAIL reset_ram_a: got %h expected 0", ram_a); end
    n_cmp++; if ({ram_wr, ram_dout, if_done, mem_done} !== 11'd0) begin n_bad++; $display("FAIL reset_ctrl: got %h expected 0", {ram_wr, ram_dout, if_done, mem_done}); end
    n_cmp++; if ({if_data, mem_rdata} !== 64'd0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", {if_data, mem_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_lw_basic();
    logic [31:0] got; int lat; bit stray;
    poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
    do_txn(1'b0, 1'b0, 32'h100, SIZE_W, 1'b0, 32'd0, got, lat, stray);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL lw_latency: got %0d expected 6", lat); end
    n_cmp++; if (got !== 32'h4433_2211) begin n_bad++; $display("FAIL lw_data: got %h expected 44332211", got); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (a_trace[k] !== ADDR_W'(32'h100 + k)) begin
        n_bad++; $display("FAIL lw_addr%0d: got %h expected %h", k, a_trace[k], 32'h100 + k);
      end
    end
  endtask

  task automatic test_lb_sign();
    logic [31:0] got; int lat; bit stray;
    poke(17'h10, 8'h80);
    do_txn(1'b0, 1'b0, 32'h10, SIZE_B, 1'b0, 32'd0, got, lat, stray);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lb_latency: got %0d expected 3", lat); end
    n_cmp++; if (got !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h expected ffffff80", got); end
    do_txn(1'b0, 1'b0, 32'h10, SIZE_B, 1'b1, 32'd0, got, lat, stray);
    n_cmp++; if (got !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_data: got %h expected 00000080", got); end
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL rdata_hold: got %h expected 00000080", mem_rdata); end
  endtask

  task automatic test_sh();
    logic [31:0] got; int lat; bit stray;
    do_txn(1'b0, 1'b1, 32'h201, SIZE_H, 1'b0, 32'h0000_ABCD, got, lat, stray);
    ref_mem[17'h201] = 8'hCD; ref_mem[17'h202] = 8'hAB;
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sh_latency: got %0d expected 3", lat); end
    n_cmp++; if (wr_log.size() !== 2) begin n_bad++; $display("FAIL sh_wr_count: got %0d expected 2", wr_log.size()); end
    else begin
      n_cmp++; if (wr_log[0] !== {17'h201, 8'hCD}) begin n_bad++; $display("FAIL sh_wr0: got %h expected %h", wr_log[0], {17'h201, 8'hCD}); end
      n_cmp++; if (wr_log[1] !== {17'h202, 8'hAB}) begin n_bad++; $display("FAIL sh_wr1: got %h expected %h", wr_log[1], {17'h202, 8'hAB}); end
    end
  endtask

  task automatic test_arbitration();
    int lat = 0;
    bit seen_if = 1'b0;
    logic [31:0] exp_m, exp_i;
    for (int k = 0; k < 4; k++) begin
      poke(ADDR_W'(k), 8'($urandom)); poke(ADDR_W'(32'h40 + k), 8'($urandom));
    end
    exp_m = ref_load(32'h40, 4, 1'b1);
    exp_i = ref_load(32'h0, 4, 1'b1);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_size = SIZE_W; mem_unsigned = 1'b0;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (if_done) seen_if = 1'b1;
      if (mem_done) break;
    end
    mem_req = 1'b0;
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL arb_mem_latency: got %0d expected 6", lat); end
    n_cmp++; if (seen_if !== 1'b0) begin n_bad++; $display("FAIL arb_if_early: got %b expected 0", seen_if); end
    n_cmp++; if (mem_rdata !== exp_m) begin n_bad++; $display("FAIL arb_mem_data: got %h expected %h", mem_rdata, exp_m); end
    lat = 0;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (if_done) break;
    end
    if_req = 1'b0;
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL arb_if_latency: got %0d expected 7", lat); end
    n_cmp++; if (if_data !== exp_i) begin n_bad++; $display("FAIL arb_if_data: got %h expected %h", if_data, exp_i); end
    n_cmp++; if (mem_rdata !== exp_m) begin n_bad++; $display("FAIL arb_rdata_hold: got %h expected %h", mem_rdata, exp_m); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got; int lat; bit stray;
    bit seen = 1'b0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_size = SIZE_W; mem_unsigned = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL rstmid_ram_wr: got %b expected 0", ram_wr); end
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, IDLE); end
    n_cmp++; if (mem_rdata !== 32'd0) begin n_bad++; $display("FAIL rstmid_rdata: got %h expected 0", mem_rdata); end
    rst = 1'b0; mem_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_done || if_done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got %b expected 0", seen); end
    do_txn(1'b0, 1'b0, 32'h100, SIZE_W, 1'b0, 32'd0, got, lat, stray);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL rstmid_lw_latency: got %0d expected 6", lat); end
    n_cmp++; if (got !== ref_load(32'h100, 4, 1'b0)) begin n_bad++; $display("FAIL rstmid_lw_data: got %h expected %h", got, ref_load(32'h100, 4, 1'b0)); end
  endtask

  task automatic test_io_stall();
    int lat = 0;
    int exp_lat;
    @(negedge clk);
    wr_log.delete();
    io_buffer_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0003_0000; mem_size = SIZE_B; mem_wdata = 32'h0000_0041;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (lat == 4) io_buffer_full = 1'b0;
      if (mem_done) break;
    end
    mem_req = 1'b0; io_buffer_full = 1'b0;
    ref_mem[17'h10000] = 8'h41;
`ifdef MEM_CTRL_IO_STALL_EN
    exp_lat = 5;
`else
    exp_lat = 2;
`endif
    n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL io_latency: got %0d expected %0d", lat, exp_lat); end
    n_cmp++; if (wr_log.size() !== 1) begin n_bad++; $display("FAIL io_wr_count: got %0d expected 1", wr_log.size()); end
    else begin
      n_cmp++; if (wr_log[0] !== {17'h10000, 8'h41}) begin n_bad++; $display("FAIL io_wr: got %h expected %h", wr_log[0], {17'h10000, 8'h41}); end
    end
  endtask

  task automatic test_random();
    logic [31:0] got, addr, wdata, exp;
    int lat, n, sel;
    bit stray, is_if, we, uns;
    logic [1:0] size;
    for (int t = 0; t < 80; t++) begin
      is_if = ($urandom_range(0, 3) == 0);
      we    = is_if ? 1'b0 : 1'($urandom);
      uns   = 1'($urandom);
      size  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      sel   = $urandom_range(0, 3);
      if (sel < 2) addr = $urandom_range(0, 32'h3FF);
      else if (sel == 2) addr = 32'h1FFFC + $urandom_range(0, 3);
      else addr = $urandom;
      n = nbytes(is_if, size);
      exp_q.delete();
      exp = ref_load(addr, n, is_if ? 1'b1 : uns);
      if (we) ref_store(addr, n, wdata);
      do_txn(is_if, we, addr, size, uns, wdata, got, lat, stray);
      n_cmp++;
      if (lat !== (we ? n + 1 : n + 2)) begin
        n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, lat, we ? n + 1 : n + 2);
      end
      n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_stray_done: got %b expected 0", t, stray); end
      if (we) begin
        n_cmp++;
        if (wr_log.size() !== exp_q.size()) begin
          n_bad++; $display("FAIL rnd%0d_wr_count: got %0d expected %0d", t, wr_log.size(), exp_q.size());
        end else begin
          for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (wr_log[k] !== exp_q[k]) begin
              n_bad++; $display("FAIL rnd%0d_wr%0d: got %h expected %h", t, k, wr_log[k], exp_q[k]);
            end
          end
        end
      end else begin
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL rnd%0d_data: got %h expected %h", t, got, exp); end
        n_cmp++;
        if (wr_log.size() !== 0) begin n_bad++; $display("FAIL rnd%0d_read_wr: got %0d expected 0", t, wr_log.size()); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < MEM_SZ; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_lw_basic();
    test_lb_sign();
    test_sh();
    test_arbitration();
    test_reset_mid();
    test_io_stall();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-side responder serving word-level load/store and instruction-fetch requests.
- Requests come from the MEM stage and the IF stage of the RISC-V pipeline.
- Serialises each request into byte accesses on an 8-bit synchronous RAM/IO bus.
- Assembles load results, applies sign/zero extension, and returns data with a one-cycle done pulse. Requesters stall until done.

Parameters:
- ADDR_W, 17, width of the RAM byte address bus.
- IO_BASE, 32'h0003_0000, first address of the IO region. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  32  fetch byte address.
- if_done  out  1  one-cycle pulse; if_data valid this cycle.
- if_data  out  32  fetched instruction word, little-endian.
- mem_req  in  1  load/store request; held until mem_done.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  32  byte address.
- mem_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- mem_unsigned  in  1  zero-extend the load result (LBU/LHU).
- mem_wdata  in  32  store data; low bytes are used.
- mem_done  out  1  one-cycle pulse; mem_rdata valid this cycle.
- mem_rdata  out  32  extended load result.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  byte written to RAM.
- ram_din  in  8  byte read from RAM; returned one cycle after ram_a is presented.
- io_buffer_full  in  1  IO write buffer full. Used only with the optional feature.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, counter 0, all outputs 0 (ram_a=0, ram_wr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0).
- Reset mid-operation aborts the access: no done pulse, ram_wr low on the next cycle.
- States:
  - IDLE
  - READ
  - WRITE
  - DONE (one cycle, asserts the selected done)
- Byte count n:
  - byte → 1
  - half → 2
  - word → 4
  - fetch → always 4
- Arbitration in IDLE:
  - mem_req beats if_req.
  - Request fields are latched on the accept edge; later input changes are ignored.
- READ:
  - Cycle k (k=0..n-1) drives ram_a=addr[ADDR_W-1:0]+k, truncated so it wraps at 2^ADDR_W.
  - The byte on ram_din in cycle k+1 is stored at byte lane k.
  - Stays in READ for n+1 cycles, then goes to DONE.
  - Load done appears n+2 cycles after the accept edge: LB 3, LH 4, LW 6.
- WRITE:
  - Cycle k drives ram_wr=1, ram_a=addr+k, ram_dout=wdata[8k+7:8k].
  - Lasts n cycles, then DONE.
  - Store done at cycle n+1: SB 2, SW 5.
- DONE:
  - Pulses the selected done and drives if_data or mem_rdata.
  - Returns to IDLE next cycle.
  - Requests present in the DONE cycle are ignored; requesters drop their request on done.
  - A new request is accepted one cycle after DONE.
- Extension:
  - Byte/half loads are sign-extended from bit 7/15 unless mem_unsigned=1.
  - Word loads pass through unchanged.
- Misaligned addresses are legal; access stays byte-serial with no exception.
- Outside WRITE, ram_wr=0 always.
- mem_rdata and if_data hold their last value between done pulses.

Optional Feature:
- Macro: MEM_CTRL_IO_STALL_EN.
- Defined:
  - In WRITE, if the address is ≥ IO_BASE and io_buffer_full=1, ram_wr is held at 0 and the counter freezes.
  - The write resumes once io_buffer_full=0; done latency grows by the number of stalled cycles.
  - io_buffer_full is sampled each cycle.
- Undefined: io_buffer_full is ignored and IO_BASE is unused.

Decomposition:
- Package mem_ctrl_pkg holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W
  - state enum (IDLE, READ, WRITE, DONE)
  - requester-select encoding
  - default IO_BASE constant
- One sub-module, mem_ctrl_extend: combinational sign/zero extension taking the 32-bit raw value, size and unsigned flag.

Test Plan:
- LW at 0x100 with RAM bytes 11,22,33,44 → ram_a shows 0x100..0x103; mem_done at cycle 6; mem_rdata=0x44332211.
- LB at 0x10 holding 0x80 → mem_rdata=0xFFFFFF80; repeated as LBU → 0x00000080.
- SH 0x0000ABCD at 0x201 → ram_wr high 2 cycles with (0x201,CD) then (0x202,AB); mem_done at cycle 3.
- if_req at 0x0 and mem_req (LW at 0x40) raised in the same cycle → MEM served first; IF accepted one cycle after mem_done; if_done carries the word at 0x0.
- rst pulsed in the 2nd READ cycle of an LW → next cycle ram_wr=0, state IDLE, no done pulse; a fresh LW afterwards completes normally.
- With MEM_CTRL_IO_STALL_EN defined: SB 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → ram_wr stays low 3 cycles, then one write; mem_done at cycle 5.
